// File: rtl/roce_traffic_role.sv
// RoCE traffic-generator role: issues RDMA READ/WRITE commands, streams WRITE payload,
// tracks completions with bounded outstanding commands, timeout and ap_* handshake.
module roce_traffic_role #(
    parameter int unsigned C_M_AXIS_TX_META_TDATA_WIDTH   = 256,
    parameter int unsigned C_M_AXIS_TX_DATA_TDATA_WIDTH   = 512,
    parameter int unsigned C_S_AXIS_TX_STATUS_TDATA_WIDTH = 512,
    parameter int unsigned C_MAX_OUTSTANDING              = 8
) (
    input  logic                                          ap_clk,
    input  logic                                          areset,

    output logic                                          m_axis_tx_meta_tvalid,
    input  logic                                          m_axis_tx_meta_tready,
    output logic [C_M_AXIS_TX_META_TDATA_WIDTH-1:0]       m_axis_tx_meta_tdata,
    output logic [C_M_AXIS_TX_META_TDATA_WIDTH/8-1:0]     m_axis_tx_meta_tkeep,
    output logic                                          m_axis_tx_meta_tlast,

    output logic                                          m_axis_tx_data_tvalid,
    input  logic                                          m_axis_tx_data_tready,
    output logic [C_M_AXIS_TX_DATA_TDATA_WIDTH-1:0]       m_axis_tx_data_tdata,
    output logic [C_M_AXIS_TX_DATA_TDATA_WIDTH/8-1:0]     m_axis_tx_data_tkeep,
    output logic                                          m_axis_tx_data_tlast,

    input  logic                                          s_axis_tx_status_tvalid,
    output logic                                          s_axis_tx_status_tready,
    input  logic [C_S_AXIS_TX_STATUS_TDATA_WIDTH-1:0]     s_axis_tx_status_tdata,
    input  logic [C_S_AXIS_TX_STATUS_TDATA_WIDTH/8-1:0]   s_axis_tx_status_tkeep,
    input  logic                                          s_axis_tx_status_tlast,

    input  logic                                          ap_start,
    output logic                                          ap_idle,
    output logic                                          ap_done,
    output logic                                          ap_ready,

    input  logic [31:0]                                   ctrl_num_ops,
    input  logic                                          ctrl_op,
    input  logic [23:0]                                   ctrl_qpn,
    input  logic [31:0]                                   ctrl_length,
    input  logic [63:0]                                   ctrl_laddr,
    input  logic [63:0]                                   ctrl_raddr,
    input  logic [31:0]                                   ctrl_timeout,

    output logic [31:0]                                   stat_ok_cnt,
    output logic [31:0]                                   stat_err_cnt,
    output logic [31:0]                                   stat_cycles,
    output logic                                          stat_timeout
);

    localparam int unsigned META_W     = C_M_AXIS_TX_META_TDATA_WIDTH;
    localparam int unsigned DATA_W     = C_M_AXIS_TX_DATA_TDATA_WIDTH;
    localparam int unsigned DATA_BYTES = DATA_W / 8;
    localparam int unsigned DATA_WORDS = DATA_W / 32;
    localparam int unsigned BEAT_LOG   = $clog2(DATA_BYTES);
    localparam int unsigned OUT_W      = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DATA,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic                  ap_start_r;
    logic [31:0]           num_q, num_d;
    logic                  op_q, op_d;
    logic [23:0]           qpn_q, qpn_d;
    logic [31:0]           len_q, len_d;
    logic [63:0]           laddr_q, laddr_d;
    logic [63:0]           raddr_q, raddr_d;
    logic [31:0]           to_q, to_d;
    logic [31:0]           issued_q, issued_d;
    logic [63:0]           offset_q, offset_d;
    logic [OUT_W-1:0]      out_q, out_d;
    logic [31:0]           beat_q, beat_d;
    logic [15:0]           data_k_q, data_k_d;

    logic                  meta_tvalid_d, meta_tlast_d;
    logic [META_W-1:0]     meta_tdata_d;
    logic [META_W/8-1:0]   meta_tkeep_d;
    logic                  data_tvalid_d, data_tlast_d;
    logic [DATA_W-1:0]     data_tdata_d;
    logic [DATA_BYTES-1:0] data_tkeep_d;
    logic                  status_tready_d;
    logic                  ap_idle_d, ap_done_d;
    logic [31:0]           ok_d, err_d, cycles_d;
    logic                  timeout_d;

    logic                  start_pulse, meta_hs, data_hs, st_hs, active, timeout_hit;
    logic [31:0]           beats_total;
    logic [BEAT_LOG-1:0]   len_rem;
    logic [DATA_BYTES-1:0] last_keep;
    logic                  status_unused;

    assign start_pulse   = ap_start & ~ap_start_r;
    assign meta_hs       = m_axis_tx_meta_tvalid & m_axis_tx_meta_tready;
    assign data_hs       = m_axis_tx_data_tvalid & m_axis_tx_data_tready;
    assign st_hs         = s_axis_tx_status_tvalid & s_axis_tx_status_tready;
    assign active        = (state_q == S_ISSUE) || (state_q == S_DATA) || (state_q == S_DRAIN);
    assign timeout_hit   = active && (to_q != 32'd0) && (stat_cycles == to_q - 32'd1);
    assign len_rem       = len_q[BEAT_LOG-1:0];
    assign beats_total   = (len_q >> BEAT_LOG) + 32'(|len_rem);
    assign status_unused = ^{s_axis_tx_status_tkeep, s_axis_tx_status_tlast,
                             s_axis_tx_status_tdata[C_S_AXIS_TX_STATUS_TDATA_WIDTH-1:1]};

    // Byte enables of the final payload beat; a zero remainder means a full beat.
    always_comb begin
        last_keep = '0;
        for (int unsigned i = 0; i < DATA_BYTES; i++) begin
            last_keep[i] = (len_rem == '0) || (i < 32'(len_rem));
        end
    end

    // Next-state, counters and next values of all registered outputs.
    always_comb begin
        state_d   = state_q;
        num_d     = num_q;
        op_d      = op_q;
        qpn_d     = qpn_q;
        len_d     = len_q;
        laddr_d   = laddr_q;
        raddr_d   = raddr_q;
        to_d      = to_q;
        issued_d  = issued_q;
        offset_d  = offset_q;
        out_d     = out_q;
        beat_d    = beat_q;
        data_k_d  = data_k_q;
        ok_d      = stat_ok_cnt;
        err_d     = stat_err_cnt;
        cycles_d  = stat_cycles;
        timeout_d = stat_timeout;

        unique case ({meta_hs, st_hs})
            2'b10:   out_d = out_q + OUT_W'(1);
            2'b01:   out_d = (out_q == '0) ? '0 : out_q - OUT_W'(1);
            default: out_d = out_q;
        endcase

        // A completion with nothing outstanding is treated as an error.
        if (st_hs) begin
            if (s_axis_tx_status_tdata[0] || ((out_q == '0) && !meta_hs)) begin
                err_d = stat_err_cnt + 32'd1;
            end else begin
                ok_d = stat_ok_cnt + 32'd1;
            end
        end

        if (active) begin
            cycles_d = stat_cycles + 32'd1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start_pulse) begin
                    num_d     = ctrl_num_ops;
                    op_d      = ctrl_op;
                    qpn_d     = ctrl_qpn;
                    len_d     = ctrl_length;
                    laddr_d   = ctrl_laddr;
                    raddr_d   = ctrl_raddr;
                    to_d      = ctrl_timeout;
                    issued_d  = 32'd0;
                    offset_d  = 64'd0;
                    out_d     = '0;
                    ok_d      = 32'd0;
                    err_d     = 32'd0;
                    cycles_d  = 32'd0;
                    timeout_d = 1'b0;
                    state_d   = (ctrl_num_ops == 32'd0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (meta_hs) begin
                    issued_d = issued_q + 32'd1;
                    offset_d = offset_q + 64'(len_q);
                    data_k_d = issued_q[15:0];
                    beat_d   = 32'd0;
                    if (op_q && (len_q != 32'd0)) begin
                        state_d = S_DATA;
                    end else if (issued_q + 32'd1 == num_q) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DATA: begin
                if (data_hs) begin
                    if (m_axis_tx_data_tlast) begin
                        state_d = (issued_q == num_q) ? S_DRAIN : S_ISSUE;
                    end else begin
                        beat_d = beat_q + 32'd1;
                    end
                end
            end
            S_DRAIN: begin
                if (out_d == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (timeout_hit) begin
            state_d   = S_DONE;
            timeout_d = 1'b1;
        end

        meta_tvalid_d = (state_d == S_ISSUE) && (out_d < OUT_W'(C_MAX_OUTSTANDING));
        meta_tdata_d  = '0;
        if (meta_tvalid_d) begin
            meta_tdata_d[23:0]    = qpn_d;
            meta_tdata_d[24]      = op_d;
            meta_tdata_d[95:32]   = laddr_d + offset_d;
            meta_tdata_d[159:96]  = raddr_d + offset_d;
            meta_tdata_d[191:160] = len_d;
        end
        meta_tkeep_d = meta_tvalid_d ? '1 : '0;
        meta_tlast_d = meta_tvalid_d;

        data_tvalid_d = (state_d == S_DATA);
        data_tlast_d  = data_tvalid_d && (beat_d == beats_total - 32'd1);
        data_tdata_d  = data_tvalid_d ? {DATA_WORDS{data_k_d, beat_d[15:0]}} : '0;
        data_tkeep_d  = data_tvalid_d ? (data_tlast_d ? last_keep : '1) : '0;

        status_tready_d = (state_d == S_ISSUE) || (state_d == S_DATA) || (state_d == S_DRAIN);
        ap_idle_d       = (state_d == S_IDLE);
        ap_done_d       = (state_d == S_DONE);
    end

    // State, context and output registers.
    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset) begin
            state_q                 <= S_IDLE;
            ap_start_r              <= 1'b0;
            num_q                   <= '0;
            op_q                    <= 1'b0;
            qpn_q                   <= '0;
            len_q                   <= '0;
            laddr_q                 <= '0;
            raddr_q                 <= '0;
            to_q                    <= '0;
            issued_q                <= '0;
            offset_q                <= '0;
            out_q                   <= '0;
            beat_q                  <= '0;
            data_k_q                <= '0;
            m_axis_tx_meta_tvalid   <= 1'b0;
            m_axis_tx_meta_tdata    <= '0;
            m_axis_tx_meta_tkeep    <= '0;
            m_axis_tx_meta_tlast    <= 1'b0;
            m_axis_tx_data_tvalid   <= 1'b0;
            m_axis_tx_data_tdata    <= '0;
            m_axis_tx_data_tkeep    <= '0;
            m_axis_tx_data_tlast    <= 1'b0;
            s_axis_tx_status_tready <= 1'b0;
            ap_idle                 <= 1'b1;
            ap_done                 <= 1'b0;
            ap_ready                <= 1'b0;
            stat_ok_cnt             <= '0;
            stat_err_cnt            <= '0;
            stat_cycles             <= '0;
            stat_timeout            <= 1'b0;
        end else begin
            state_q                 <= state_d;
            ap_start_r              <= ap_start;
            num_q                   <= num_d;
            op_q                    <= op_d;
            qpn_q                   <= qpn_d;
            len_q                   <= len_d;
            laddr_q                 <= laddr_d;
            raddr_q                 <= raddr_d;
            to_q                    <= to_d;
            issued_q                <= issued_d;
            offset_q                <= offset_d;
            out_q                   <= out_d;
            beat_q                  <= beat_d;
            data_k_q                <= data_k_d;
            m_axis_tx_meta_tvalid   <= meta_tvalid_d;
            m_axis_tx_meta_tdata    <= meta_tdata_d;
            m_axis_tx_meta_tkeep    <= meta_tkeep_d;
            m_axis_tx_meta_tlast    <= meta_tlast_d;
            m_axis_tx_data_tvalid   <= data_tvalid_d;
            m_axis_tx_data_tdata    <= data_tdata_d;
            m_axis_tx_data_tkeep    <= data_tkeep_d;
            m_axis_tx_data_tlast    <= data_tlast_d;
            s_axis_tx_status_tready <= status_tready_d;
            ap_idle                 <= ap_idle_d;
            ap_done                 <= ap_done_d;
            ap_ready                <= ap_done_d;
            stat_ok_cnt             <= ok_d;
            stat_err_cnt            <= err_d;
            stat_cycles             <= cycles_d;
            stat_timeout            <= timeout_d;
        end
    end

endmodule

// File: tb/tb_roce_traffic_role.sv
// Directed self-checking bench for roce_traffic_role with default parameters.
module tb_roce_traffic_role;

    localparam int unsigned META_W = 256;
    localparam int unsigned DATA_W = 512;
    localparam int unsigned ST_W   = 512;

    logic                  ap_clk = 1'b0;
    logic                  areset;
    logic                  m_tvalid, m_tready, m_tlast;
    logic [META_W-1:0]     m_tdata;
    logic [META_W/8-1:0]   m_tkeep;
    logic                  d_tvalid, d_tready, d_tlast;
    logic [DATA_W-1:0]     d_tdata;
    logic [DATA_W/8-1:0]   d_tkeep;
    logic                  s_tvalid, s_tready, s_tlast;
    logic [ST_W-1:0]       s_tdata;
    logic [ST_W/8-1:0]     s_tkeep;
    logic                  ap_start, ap_idle, ap_done, ap_ready;
    logic [31:0]           ctrl_num_ops, ctrl_length, ctrl_timeout;
    logic                  ctrl_op;
    logic [23:0]           ctrl_qpn;
    logic [63:0]           ctrl_laddr, ctrl_raddr;
    logic [31:0]           stat_ok_cnt, stat_err_cnt, stat_cycles;
    logic                  stat_timeout;

    int n_assert = 0;
    int n_fail   = 0;

    logic [META_W-1:0]   meta_q[$];
    logic [DATA_W-1:0]   dq_data[$];
    logic [DATA_W/8-1:0] dq_keep[$];
    logic                dq_last[$];
    int                  done_cnt = 0;
    int                  oc       = 0;
    int                  max_oc   = 0;

    always #5 ap_clk = ~ap_clk;

    roce_traffic_role dut (
        .ap_clk                  (ap_clk),
        .areset                  (areset),
        .m_axis_tx_meta_tvalid   (m_tvalid),
        .m_axis_tx_meta_tready   (m_tready),
        .m_axis_tx_meta_tdata    (m_tdata),
        .m_axis_tx_meta_tkeep    (m_tkeep),
        .m_axis_tx_meta_tlast    (m_tlast),
        .m_axis_tx_data_tvalid   (d_tvalid),
        .m_axis_tx_data_tready   (d_tready),
        .m_axis_tx_data_tdata    (d_tdata),
        .m_axis_tx_data_tkeep    (d_tkeep),
        .m_axis_tx_data_tlast    (d_tlast),
        .s_axis_tx_status_tvalid (s_tvalid),
        .s_axis_tx_status_tready (s_tready),
        .s_axis_tx_status_tdata  (s_tdata),
        .s_axis_tx_status_tkeep  (s_tkeep),
        .s_axis_tx_status_tlast  (s_tlast),
        .ap_start                (ap_start),
        .ap_idle                 (ap_idle),
        .ap_done                 (ap_done),
        .ap_ready                (ap_ready),
        .ctrl_num_ops            (ctrl_num_ops),
        .ctrl_op                 (ctrl_op),
        .ctrl_qpn                (ctrl_qpn),
        .ctrl_length             (ctrl_length),
        .ctrl_laddr              (ctrl_laddr),
        .ctrl_raddr              (ctrl_raddr),
        .ctrl_timeout            (ctrl_timeout),
        .stat_ok_cnt             (stat_ok_cnt),
        .stat_err_cnt            (stat_err_cnt),
        .stat_cycles             (stat_cycles),
        .stat_timeout            (stat_timeout)
    );

    function automatic int oc_next(input int cur, input logic mh, input logic sh);
        if (mh && !sh) return cur + 1;
        if (sh && !mh) return (cur == 0) ? 0 : cur - 1;
        return cur;
    endfunction

    // Bus monitor: records accepted beats, done pulses and the outstanding level.
    always @(posedge ap_clk) begin
        if (m_tvalid && m_tready) meta_q.push_back(m_tdata);
        if (d_tvalid && d_tready) begin
            dq_data.push_back(d_tdata);
            dq_keep.push_back(d_tkeep);
            dq_last.push_back(d_tlast);
        end
        if (ap_done) done_cnt <= done_cnt + 1;
        if (areset) begin
            oc <= 0;
        end else begin
            oc <= oc_next(oc, m_tvalid && m_tready, s_tvalid && s_tready);
            if (oc_next(oc, m_tvalid && m_tready, s_tvalid && s_tready) > max_oc)
                max_oc <= oc_next(oc, m_tvalid && m_tready, s_tvalid && s_tready);
        end
    end

    function automatic logic [META_W-1:0] exp_meta(input logic [23:0] qpn, input logic op,
                                                   input logic [63:0] la, input logic [63:0] ra,
                                                   input logic [31:0] len, input int k);
        logic [META_W-1:0] w;
        w = '0;
        w[23:0]    = qpn;
        w[24]      = op;
        w[95:32]   = la + 64'(k) * 64'(len);
        w[159:96]  = ra + 64'(k) * 64'(len);
        w[191:160] = len;
        return w;
    endfunction

    function automatic logic [DATA_W-1:0] exp_data(input int k, input int b);
        logic [DATA_W-1:0] w;
        for (int i = 0; i < DATA_W / 32; i++) w[i*32 +: 32] = {k[15:0], b[15:0]};
        return w;
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic start_run(input logic [31:0] nops, input logic op, input logic [31:0] len,
                             input logic [63:0] la, input logic [63:0] ra, input logic [31:0] to);
        ctrl_num_ops = nops;
        ctrl_op      = op;
        ctrl_length  = len;
        ctrl_laddr   = la;
        ctrl_raddr   = ra;
        ctrl_timeout = to;
        ap_start     = 1'b1;
        tick();
        ap_start     = 1'b0;
    endtask

    task automatic send_status(input logic err);
        logic rdy;
        s_tvalid = 1'b1;
        s_tdata  = '0;
        s_tdata[0] = err;
        for (int i = 0; i < 200; i++) begin
            rdy = s_tready;
            tick();
            if (rdy) break;
        end
        s_tvalid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (ap_done) break;
            tick();
        end
        chk(tag, ap_done, 1'b1);
    endtask

    task automatic wait_metas(input string tag, input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (meta_q.size() >= target) break;
            tick();
        end
        chk(tag, meta_q.size(), target);
    endtask

    task automatic wait_beats(input string tag, input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (dq_data.size() >= target) break;
            tick();
        end
        chk(tag, dq_data.size(), target);
    endtask

    initial begin
        int mbase, dbase, dn, sent, n, errs;
        logic hs;
        logic [63:0] keep36;

        keep36       = 64'h0000_000F_FFFF_FFFF;
        areset       = 1'b1;
        m_tready     = 1'b0;
        d_tready     = 1'b0;
        s_tvalid     = 1'b0;
        s_tdata      = '0;
        s_tkeep      = '0;
        s_tlast      = 1'b0;
        ap_start     = 1'b0;
        ctrl_num_ops = '0;
        ctrl_op      = 1'b0;
        ctrl_qpn     = 24'h123456;
        ctrl_length  = '0;
        ctrl_laddr   = '0;
        ctrl_raddr   = '0;
        ctrl_timeout = '0;
        repeat (2) tick();

        chk("rst_ap_idle", ap_idle, 1'b1);
        chk("rst_ap_done", ap_done, 1'b0);
        chk("rst_ap_ready", ap_ready, 1'b0);
        chk("rst_meta_tvalid", m_tvalid, 1'b0);
        chk("rst_meta_tdata", m_tdata, '0);
        chk("rst_data_tvalid", d_tvalid, 1'b0);
        chk("rst_status_tready", s_tready, 1'b0);
        chk("rst_stat_ok", stat_ok_cnt, 32'd0);
        chk("rst_stat_timeout", stat_timeout, 1'b0);
        areset = 1'b0;
        tick();

        // READ x4, 4 KiB each
        m_tready = 1'b1;
        d_tready = 1'b1;
        mbase = meta_q.size();
        dn    = done_cnt;
        start_run(4, 1'b0, 4096, 64'h1000, 64'h8000, 0);
        chk("t1_first_meta_latency", m_tvalid, 1'b1);
        chk("t1_idle_fall", ap_idle, 1'b0);
        wait_metas("t1_meta_count", mbase + 4, 100);
        for (int k = 0; k < 4; k++)
            chk("t1_meta_word", meta_q[mbase + k], exp_meta(24'h123456, 1'b0, 64'h1000, 64'h8000, 4096, k));
        repeat (4) send_status(1'b0);
        wait_done("t1_done", 100);
        chk("t1_ap_ready", ap_ready, 1'b1);
        chk("t1_ok", stat_ok_cnt, 32'd4);
        chk("t1_err", stat_err_cnt, 32'd0);
        tick();
        chk("t1_done_pulse_end", ap_done, 1'b0);
        chk("t1_idle_rise", ap_idle, 1'b1);
        chk("t1_done_count", done_cnt - dn, 1);

        // WRITE x2, 100 bytes: two beats each, 36-byte tail
        mbase = meta_q.size();
        dbase = dq_data.size();
        start_run(2, 1'b1, 100, 64'h0, 64'h100, 0);
        chk("t2_meta_valid", m_tvalid, 1'b1);
        tick();
        chk("t2_data_latency", d_tvalid, 1'b1);
        chk("t2_meta_after_hs", m_tvalid, 1'b0);
        wait_beats("t2_beat_count", dbase + 4, 100);
        for (int b = 0; b < 4; b++) begin
            chk("t2_tdata", dq_data[dbase + b], exp_data(b / 2, b % 2));
            chk("t2_tkeep", dq_keep[dbase + b], (b % 2 == 1) ? keep36 : 64'hFFFF_FFFF_FFFF_FFFF);
            chk("t2_tlast", dq_last[dbase + b], (b % 2 == 1) ? 1'b1 : 1'b0);
        end
        wait_metas("t2_meta_count", mbase + 2, 50);
        chk("t2_meta1_word", meta_q[mbase + 1], exp_meta(24'h123456, 1'b1, 64'h0, 64'h100, 100, 1));
        repeat (2) send_status(1'b0);
        wait_done("t2_done", 100);
        chk("t2_ok", stat_ok_cnt, 32'd2);
        tick();

        // 20 READs with completions withheld: stall at 8 outstanding
        mbase = meta_q.size();
        start_run(20, 1'b0, 64, 64'h0, 64'h0, 0);
        repeat (30) tick();
        chk("t3_stall_count", meta_q.size() - mbase, 8);
        chk("t3_stall_tvalid", m_tvalid, 1'b0);
        for (int i = 0; i < 20; i++) send_status(i == 5);
        wait_done("t3_done", 100);
        chk("t3_meta_total", meta_q.size() - mbase, 20);
        chk("t3_ok", stat_ok_cnt, 32'd19);
        chk("t3_err", stat_err_cnt, 32'd1);
        chk("t3_max_outstanding", max_oc, 8);
        tick();

        // Random backpressure, WRITE x10 of 130 bytes, remote address wraps
        mbase = meta_q.size();
        dbase = dq_data.size();
        sent  = 0;
        start_run(10, 1'b1, 130, 64'h10_0000_0000, 64'hFFFF_FFFF_FFFF_FF00, 0);
        for (int c = 0; c < 3000; c++) begin
            if (ap_done) break;
            m_tready = 1'($urandom_range(0, 1));
            d_tready = 1'($urandom_range(0, 1));
            if (!s_tvalid && (meta_q.size() - mbase - sent) > 0 && $urandom_range(0, 1) == 1) begin
                s_tvalid = 1'b1;
                s_tdata  = '0;
            end
            hs = s_tvalid && s_tready;
            tick();
            if (hs) begin
                sent++;
                s_tvalid = 1'b0;
            end
        end
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        d_tready = 1'b1;
        chk("t4_done", ap_done, 1'b1);
        chk("t4_meta_total", meta_q.size() - mbase, 10);
        chk("t4_beat_total", dq_data.size() - dbase, 30);
        errs = 0;
        for (int k = 0; k < 10; k++)
            if (meta_q[mbase + k] !== exp_meta(24'h123456, 1'b1, 64'h10_0000_0000,
                                               64'hFFFF_FFFF_FFFF_FF00, 130, k)) errs++;
        chk("t4_meta_words", errs, 0);
        errs = 0;
        for (int i = 0; i < 30; i++) begin
            if (dq_data[dbase + i] !== exp_data(i / 3, i % 3)) errs++;
            if (dq_keep[dbase + i] !== ((i % 3 == 2) ? 64'h3 : 64'hFFFF_FFFF_FFFF_FFFF)) errs++;
            if (dq_last[dbase + i] !== (i % 3 == 2)) errs++;
        end
        chk("t4_beats", errs, 0);
        chk("t4_ok", stat_ok_cnt, 32'd10);
        chk("t4_max_outstanding_le8", (max_oc <= 8), 1'b1);
        tick();

        // Timeout of 50 cycles with no completions
        mbase = meta_q.size();
        start_run(20, 1'b0, 64, 64'h0, 64'h0, 50);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            if (ap_done) break;
            tick();
            n++;
        end
        chk("t5_done_after", n, 50);
        chk("t5_stat_timeout", stat_timeout, 1'b1);
        chk("t5_stat_cycles", stat_cycles, 32'd50);
        chk("t5_meta_tvalid_drop", m_tvalid, 1'b0);
        chk("t5_status_tready_drop", s_tready, 1'b0);
        chk("t5_meta_count", meta_q.size() - mbase, 8);
        repeat (2) tick();

        // Zero commands: straight to DONE, stats cleared
        start_run(0, 1'b0, 64, 64'h0, 64'h0, 0);
        chk("t6_done_immediate", ap_done, 1'b1);
        chk("t6_timeout_cleared", stat_timeout, 1'b0);
        chk("t6_cycles_cleared", stat_cycles, 32'd0);
        tick();
        chk("t6_done_pulse_end", ap_done, 1'b0);
        chk("t6_idle", ap_idle, 1'b1);
        tick();

        // Reset asserted mid-DATA, then a clean run
        d_tready = 1'b0;
        start_run(1, 1'b1, 1000, 64'h0, 64'h0, 0);
        repeat (4) tick();
        chk("t7_in_data", d_tvalid, 1'b1);
        chk("t7_data_held", d_tdata, exp_data(0, 0));
        areset = 1'b1;
        #1;
        chk("t7_rst_data_tvalid", d_tvalid, 1'b0);
        chk("t7_rst_data_tdata", d_tdata, '0);
        chk("t7_rst_data_tkeep", d_tkeep, '0);
        chk("t7_rst_status_tready", s_tready, 1'b0);
        chk("t7_rst_ap_idle", ap_idle, 1'b1);
        chk("t7_rst_stat_cycles", stat_cycles, 32'd0);
        tick();
        areset   = 1'b0;
        d_tready = 1'b1;
        tick();
        mbase = meta_q.size();
        start_run(1, 1'b0, 64, 64'h40, 64'h80, 0);
        wait_metas("t7_meta_count", mbase + 1, 50);
        chk("t7_meta_word", meta_q[mbase], exp_meta(24'h123456, 1'b0, 64'h40, 64'h80, 64, 0));
        send_status(1'b0);
        wait_done("t7_done", 50);
        chk("t7_ok", stat_ok_cnt, 32'd1);
        chk("t7_err", stat_err_cnt, 32'd0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
